// File: rtl/mem_wait_stage.sv
// Purpose: MEM stage with a word-addressed data RAM, fixed wait states and address checking.
// Latency: ready pulses WAIT_CYC+2 cycles after a valid request appears; 1 cycle for a rejected one.
// Backpressure: freeze holds upstream registers while a request is pending and ready is low.
module mem_wait_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 1024,
  parameter int WAIT_CYC  = 2,
  parameter int DEST_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN_In,
  input  logic              MEM_R_EN_In,
  input  logic              MEM_W_EN_In,
  input  logic [ADDR_W-1:0] ALU_Res_In,
  input  logic [DATA_W-1:0] Val_Rm,
  input  logic [DEST_W-1:0] Dest_In,
  output logic              WB_EN_Out,
  output logic              MEM_R_EN_Out,
  output logic [ADDR_W-1:0] ALU_Res_Out,
  output logic [DEST_W-1:0] Dest_Out,
  output logic [DATA_W-1:0] memOut,
  output logic              ready,
  output logic              freeze,
  output logic              addr_err
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_wr;
  logic [DATA_W-1:0] r_wdat;
  logic [DATA_W-1:0] r_mem_out;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_word;
  logic              w_any_op;
  logic              w_valid;
  logic              w_accept;
  logic              w_reject;
  logic              w_commit;

  // Request decode: offset from base, word index, range/alignment/op legality.
  assign w_off    = ALU_Res_In - BASE_A;
  assign w_word   = w_off >> 2;
  assign w_any_op = MEM_R_EN_In | MEM_W_EN_In;
  assign w_valid  = (ALU_Res_In >= BASE_A) && (w_word < DEPTH_A) &&
                    (ALU_Res_In[1:0] == 2'b00) && (MEM_R_EN_In ^ MEM_W_EN_In);
  assign w_accept = (r_state == S_IDLE) && w_valid;
  assign w_reject = (r_state == S_IDLE) && w_any_op && !w_valid;
  assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);

  assign WB_EN_Out    = WB_EN_In;
  assign MEM_R_EN_Out = MEM_R_EN_In;
  assign ALU_Res_Out  = ALU_Res_In;
  assign Dest_Out     = Dest_In;
  assign memOut       = r_mem_out;
  assign ready        = (r_state == S_DONE);
  assign addr_err     = ready & r_err;
  assign freeze       = w_any_op & ~ready;

  // Next-state logic: accept or reject in IDLE, count wait states in BUSY, one-cycle DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = WAIT_INIT;
        end else if (w_any_op) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_err_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_err_nxt   = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Capture index, op and store data when a request is accepted; only consumed in BUSY.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx  <= w_word[IDX_W-1:0];
      r_wr   <= MEM_W_EN_In;
      r_wdat <= Val_Rm;
    end
  end

  // Load data register: updated by a completed load (pre-write contents) or cleared on rejection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_out <= '0;
    end else if (w_commit && !r_wr) begin
      r_mem_out <= r_mem[r_idx];
    end else if (w_reject) begin
      r_mem_out <= '0;
    end
  end

  // RAM write on the commit edge; a reset on that edge cancels the store. Contents are never cleared.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && r_wr) begin
      r_mem[r_idx] <= r_wdat;
    end
  end

endmodule

// File: tb/tb_mem_wait_stage.sv
// Purpose: directed self-checking bench for mem_wait_stage (default and swept parameter sets).
// Latency: checks ready cycle counts against WAIT_CYC+2 and the 1-cycle rejection path.
// Backpressure: checks freeze stays high until ready and drops in the ready cycle.
module tb_mem_wait_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        m_rst = 1'b1, m_wb = 1'b0, m_re = 1'b0, m_we = 1'b0;
  logic [31:0] m_alu = '0, m_val = '0;
  logic [3:0]  m_dest = '0;
  logic        m_wb_o, m_re_o, m_rdy, m_frz, m_err;
  logic [31:0] m_alu_o, m_mem;
  logic [3:0]  m_dest_o;

  // shared stimulus for the swept instances
  logic        s_rst = 1'b1, s_wb = 1'b0, s_re = 1'b0, s_we = 1'b0;
  logic [31:0] s_alu = '0, s_val = '0;
  logic [3:0]  s_dest = '0;
  logic        a_wb_o, a_re_o, a_rdy, a_frz, a_err;
  logic [31:0] a_alu_o, a_mem;
  logic [3:0]  a_dest_o;
  logic        b_wb_o, b_re_o, b_rdy, b_frz, b_err;
  logic [31:0] b_alu_o, b_mem;
  logic [3:0]  b_dest_o;

  mem_wait_stage u_dut (
    .clk(clk), .rst(m_rst), .WB_EN_In(m_wb), .MEM_R_EN_In(m_re), .MEM_W_EN_In(m_we),
    .ALU_Res_In(m_alu), .Val_Rm(m_val), .Dest_In(m_dest),
    .WB_EN_Out(m_wb_o), .MEM_R_EN_Out(m_re_o), .ALU_Res_Out(m_alu_o), .Dest_Out(m_dest_o),
    .memOut(m_mem), .ready(m_rdy), .freeze(m_frz), .addr_err(m_err)
  );

  mem_wait_stage #(.DEPTH(256), .BASE_ADDR(0), .WAIT_CYC(0)) u_w0 (
    .clk(clk), .rst(s_rst), .WB_EN_In(s_wb), .MEM_R_EN_In(s_re), .MEM_W_EN_In(s_we),
    .ALU_Res_In(s_alu), .Val_Rm(s_val), .Dest_In(s_dest),
    .WB_EN_Out(a_wb_o), .MEM_R_EN_Out(a_re_o), .ALU_Res_Out(a_alu_o), .Dest_Out(a_dest_o),
    .memOut(a_mem), .ready(a_rdy), .freeze(a_frz), .addr_err(a_err)
  );

  mem_wait_stage #(.DEPTH(256), .BASE_ADDR(0), .WAIT_CYC(15)) u_w15 (
    .clk(clk), .rst(s_rst), .WB_EN_In(s_wb), .MEM_R_EN_In(s_re), .MEM_W_EN_In(s_we),
    .ALU_Res_In(s_alu), .Val_Rm(s_val), .Dest_In(s_dest),
    .WB_EN_Out(b_wb_o), .MEM_R_EN_Out(b_re_o), .ALU_Res_Out(b_alu_o), .Dest_Out(b_dest_o),
    .memOut(b_mem), .ready(b_rdy), .freeze(b_frz), .addr_err(b_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      m_re = r; m_we = w; m_alu = a; m_val = d;
    end else begin
      s_re = r; s_we = w; s_alu = a; s_val = d;
    end
  endtask

  task automatic get_out(input int sel, output logic rdy, output logic frz,
                         output logic err, output logic [31:0] mo);
    case (sel)
      0:       begin rdy = m_rdy; frz = m_frz; err = m_err; mo = m_mem; end
      1:       begin rdy = a_rdy; frz = a_frz; err = a_err; mo = a_mem; end
      default: begin rdy = b_rdy; frz = b_frz; err = b_err; mo = b_mem; end
    endcase
  endtask

  // Issue one access in the cycle after the call, watch until ready, then drop the enables.
  task automatic do_acc(input string tag, input int sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_cyc, input logic exp_err,
                        input logic chk_mo, input logic [31:0] exp_mo);
    int          cyc;
    logic        frz_ok, rdy, frz, err, err_at, frz_at;
    logic [31:0] mo, mo_at;
    @(posedge clk); #1;
    set_req(sel, r, w, a, d);
    cyc = -1; frz_ok = 1'b1; err_at = 1'b0; frz_at = 1'b1; mo_at = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      get_out(sel, rdy, frz, err, mo);
      if (rdy) begin
        cyc = c; err_at = err; frz_at = frz; mo_at = mo;
        break;
      end
      if (!frz) frz_ok = 1'b0;
    end
    set_req(sel, 1'b0, 1'b0, a, d);
    chk({tag, " ready_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, " addr_err"}, 64'(err_at), 64'(exp_err));
    chk({tag, " freeze_before_ready"}, 64'(frz_ok), 64'd1);
    chk({tag, " freeze_at_ready"}, 64'(frz_at), 64'd0);
    if (chk_mo) chk({tag, " memOut"}, 64'(mo_at), 64'(exp_mo));
  endtask

  initial begin
    logic seen;

    // reset state and pass-through while held in reset
    repeat (2) @(posedge clk);
    #1;
    m_wb = 1'b1; m_re = 1'b1; m_dest = 4'hA; m_alu = 32'h0000_1234;
    @(negedge clk);
    chk("rst freeze_with_en", 64'(m_frz), 64'd1);
    chk("rst ready", 64'(m_rdy), 64'd0);
    chk("pass wb", 64'(m_wb_o), 64'd1);
    chk("pass re", 64'(m_re_o), 64'd1);
    chk("pass dest", 64'(m_dest_o), 64'hA);
    chk("pass alu", 64'(m_alu_o), 64'h1234);
    m_re = 1'b0; m_wb = 1'b0;
    #1;
    chk("rst freeze_no_en", 64'(m_frz), 64'd0);
    chk("rst memOut", 64'(m_mem), 64'd0);
    chk("rst addr_err", 64'(m_err), 64'd0);
    @(posedge clk); #1;
    m_rst = 1'b0;

    // stores and loads at WAIT_CYC=2
    do_acc("st1028", 0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4, 1'b0, 1'b0, 32'h0);
    do_acc("st1024", 0, 1'b0, 1'b1, 32'd1024, 32'hA5A50001, 4, 1'b0, 1'b0, 32'h0);
    do_acc("st1032", 0, 1'b0, 1'b1, 32'd1032, 32'h0BADF00D, 4, 1'b0, 1'b0, 32'h0);
    do_acc("st1036", 0, 1'b0, 1'b1, 32'd1036, 32'h11112222, 4, 1'b0, 1'b0, 32'h0);
    do_acc("ld1028", 0, 1'b1, 1'b0, 32'd1028, 32'h0, 4, 1'b0, 1'b1, 32'hDEADBEEF);

    // range / alignment rejections clear memOut
    do_acc("ld1020", 0, 1'b1, 1'b0, 32'd1020, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    do_acc("ld1280", 0, 1'b1, 1'b0, 32'd1280, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    do_acc("ld1030", 0, 1'b1, 1'b0, 32'd1030, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    do_acc("st1026", 0, 1'b0, 1'b1, 32'd1026, 32'hFFFFFFFF, 1, 1'b1, 1'b1, 32'h0);
    do_acc("st1280", 0, 1'b0, 1'b1, 32'd1280, 32'hFFFF0000, 1, 1'b1, 1'b1, 32'h0);
    do_acc("ld1024", 0, 1'b1, 1'b0, 32'd1024, 32'h0, 4, 1'b0, 1'b1, 32'hA5A50001);

    // illegal op leaves RAM alone; stores leave memOut alone
    do_acc("rw1032", 0, 1'b1, 1'b1, 32'd1032, 32'h12345678, 1, 1'b1, 1'b1, 32'h0);
    do_acc("ld1032", 0, 1'b1, 1'b0, 32'd1032, 32'h0, 4, 1'b0, 1'b1, 32'h0BADF00D);
    do_acc("st1040", 0, 1'b0, 1'b1, 32'd1040, 32'h55AA55AA, 4, 1'b0, 1'b1, 32'h0BADF00D);

    // reset in the middle of a store
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_rst = 1'b1;
    @(negedge clk);
    chk("midrst ready", 64'(m_rdy), 64'd0);
    chk("midrst freeze", 64'(m_frz), 64'd1);
    @(posedge clk); #1;
    m_rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("midrst memOut", 64'(m_mem), 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_rdy) seen = 1'b1;
    end
    chk("midrst ready_never", 64'(seen), 64'd0);
    do_acc("ld1036", 0, 1'b1, 1'b0, 32'd1036, 32'h0, 4, 1'b0, 1'b1, 32'h11112222);

    // parameter sweep: WAIT_CYC=0 instance
    @(posedge clk); #1;
    s_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s_rst = 1'b0;
    do_acc("w0 st1020", 1, 1'b0, 1'b1, 32'd1020, 32'h77665544, 2, 1'b0, 1'b0, 32'h0);
    do_acc("w0 ld1020", 1, 1'b1, 1'b0, 32'd1020, 32'h0, 2, 1'b0, 1'b1, 32'h77665544);
    do_acc("w0 ld1024", 1, 1'b1, 1'b0, 32'd1024, 32'h0, 1, 1'b1, 1'b1, 32'h0);

    // parameter sweep: WAIT_CYC=15 instance
    @(posedge clk); #1;
    s_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s_rst = 1'b0;
    do_acc("w15 st1020", 2, 1'b0, 1'b1, 32'd1020, 32'h31415926, 17, 1'b0, 1'b0, 32'h0);
    do_acc("w15 ld1020", 2, 1'b1, 1'b0, 32'd1020, 32'h0, 17, 1'b0, 1'b1, 32'h31415926);
    do_acc("w15 ld1024", 2, 1'b1, 1'b0, 32'd1024, 32'h0, 1, 1'b1, 1'b1, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wait_stage.md
Name: mem_wait_stage

Overview:
- Parametrised successor to the single-cycle MEM stage and data memory.
- Word-addressed data RAM with configurable base address, depth, data width and a fixed number of wait states.
- A freeze/ready handshake stalls the pipeline while an access is in flight.
- Flags out-of-range, misaligned and illegal accesses instead of corrupting memory.

Parameters:
- DATA_W, 32, data word width in bits (multiple of 8).
- ADDR_W, 32, width of the ALU result used as the byte address.
- DEPTH, 64, number of words in the RAM (power of two).
- BASE_ADDR, 1024, byte address of word 0.
- WAIT_CYC, 2, extra wait cycles per access (0..15).
- DEST_W, 4, destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- WB_EN_In  in  1  write-back enable from EX/MEM
- MEM_R_EN_In  in  1  load request
- MEM_W_EN_In  in  1  store request
- ALU_Res_In  in  ADDR_W  byte address / ALU result
- Val_Rm  in  DATA_W  store data
- Dest_In  in  DEST_W  destination register
- WB_EN_Out  out  1  pass-through of WB_EN_In
- MEM_R_EN_Out  out  1  pass-through of MEM_R_EN_In
- ALU_Res_Out  out  ADDR_W  pass-through of ALU_Res_In
- Dest_Out  out  DEST_W  pass-through of Dest_In
- memOut  out  DATA_W  registered load data
- ready  out  1  one-cycle pulse: access complete
- freeze  out  1  stall request to all upstream pipeline registers
- addr_err  out  1  one-cycle pulse, coincident with ready, for a rejected access

Behaviour:
- Pass-through outputs are combinational, with no added latency.
- Effective index: idx = (ALU_Res_In - BASE_ADDR) >> 2, subtraction at ADDR_W width.
- A request is valid only when:
  - ALU_Res_In >= BASE_ADDR,
  - idx < DEPTH,
  - ALU_Res_In[1:0] == 0,
  - exactly one of MEM_R_EN_In and MEM_W_EN_In is set.
- FSM states IDLE, BUSY, DONE; 4-bit wait counter cnt.
- IDLE:
  - valid request -> BUSY, cnt <= WAIT_CYC.
  - invalid request (either enable set) -> DONE with err latch set.
  - no enable -> stay.
- BUSY:
  - cnt != 0 -> cnt <= cnt - 1.
  - cnt == 0 -> commit the access on this edge, go to DONE.
  - store: RAM[idx] <= Val_Rm.
  - load: memOut <= RAM[idx] (pre-write contents).
- DONE:
  - ready = 1; addr_err = err latch.
  - Next edge -> IDLE, err cleared.
  - A new request is accepted only from IDLE, so back-to-back accesses have a one-cycle gap.
- freeze = (MEM_R_EN_In | MEM_W_EN_In) & ~ready, combinational. It is also high in the IDLE cycle where a request first appears.
- Latency: request first seen in cycle 0 -> ready high in cycle WAIT_CYC+2. With WAIT_CYC=0, ready is in cycle 2.
- Inputs are held stable by the frozen pipeline while freeze=1. The block does not re-sample the address in BUSY; it latches idx, op and store data on the IDLE->BUSY edge.
- Rejected access:
  - no RAM write; memOut <= 0.
  - ready and addr_err pulse in cycle 1.
- Load data: memOut holds its value until the next completed load or rejected access. Stores do not change memOut.
- Reset:
  - state <= IDLE, cnt <= 0, memOut <= 0, ready = 0, addr_err = 0.
  - Any in-flight store is cancelled with no RAM write.
  - RAM contents are not cleared.
  - freeze follows its equation during reset (ready = 0), so it is high if an enable input is set.
- Reading uninitialised RAM returns X in simulation; benches preload or write first.

Test Plan:
- Store, WAIT_CYC=2: W_EN=1, addr 1028, data 0xDEADBEEF in cycle 0 -> freeze=1 in cycles 0-3; ready=1, freeze=0 in cycle 4; a later load of 1028 returns 0xDEADBEEF.
- Load, WAIT_CYC=2: R_EN=1, addr 1028 after the store -> memOut=0xDEADBEEF on the edge ending cycle 3, ready in cycle 4, addr_err=0.
- Range/alignment: loads at 1020, 1024+4*64=1280 and 1030 -> each gives ready and addr_err in cycle 1, memOut=0; RAM unchanged (verified by reading word 0).
- Illegal op: R_EN=W_EN=1 at 1032, data 0x12345678 -> addr_err=1 in cycle 1; a subsequent load of 1032 returns the prior contents, not 0x12345678.
- Reset mid-store: store to 1036 with data 0xCAFEF00D, rst=1 in cycle 2 -> IDLE next cycle, ready never pulses, memOut=0; word at 1036 keeps its old value.
- Parameter sweep WAIT_CYC=0 and 15, DEPTH=256, BASE_ADDR=0 -> ready at cycles 2 and 17 respectively; addr 1020 (idx 255) accepted; addr 1024 rejected.
